// File: rtl/magnitude_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : magnitude_arbiter
// Purpose  : Round-robin scheduler sharing one magnitude datapath among
//            CHANNELS_P gradient streams. Issues one gx/gy pair per
//            handshake, records the issuing channel in an in-order tag FIFO,
//            and routes each returning magnitude back to its owner.
// Ports    : clk_i, rstn_i             - clock, async active-low reset
//            valid_i/ready_o/gx_i/gy_i - per-channel request side
//            mag_valid_o/mag_ready_i/mag_gx_o/mag_gy_o - issue to shared unit
//            mag_valid_i/mag_ready_o/mag_i - result from shared unit
//            valid_o/ready_i/mag_o     - per-channel result side
// Revision : 1.0 - initial release
// ============================================================================
module magnitude_arbiter #(
  parameter int WIDTH_P    = 8,
  parameter int CHANNELS_P = 3,
  parameter int DEPTH_P    = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [CHANNELS_P-1:0]         valid_i,
  output logic [CHANNELS_P-1:0]         ready_o,
  input  logic [CHANNELS_P*WIDTH_P-1:0] gx_i,
  input  logic [CHANNELS_P*WIDTH_P-1:0] gy_i,
  output logic                          mag_valid_o,
  input  logic                          mag_ready_i,
  output logic [WIDTH_P-1:0]            mag_gx_o,
  output logic [WIDTH_P-1:0]            mag_gy_o,
  input  logic                          mag_valid_i,
  output logic                          mag_ready_o,
  input  logic [2*WIDTH_P-1:0]          mag_i,
  output logic [CHANNELS_P-1:0]         valid_o,
  input  logic [CHANNELS_P-1:0]         ready_i,
  output logic [2*WIDTH_P-1:0]          mag_o
);

  localparam int CW = (CHANNELS_P > 1) ? $clog2(CHANNELS_P) : 1;
  localparam int AW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_COUNT = NW'(DEPTH_P);
  localparam logic [CW-1:0] LAST_CH    = CW'(CHANNELS_P - 1);
  localparam logic [CW:0]   NUM_CH     = (CW+1)'(CHANNELS_P);

  // Arbiter state
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;

  // Tag FIFO state
  logic [CW-1:0] tag_mem_q [DEPTH_P];
  logic [CW-1:0] tag_mem_d [DEPTH_P];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;

  // Combinational intermediates
  logic          grant_valid;
  logic [CW-1:0] grant_ch;
  logic [CW:0]   search_idx;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] head_ch;
  logic          head_ready;
  logic          ret_ready;
  logic          pop;
  logic          issue_valid;
  logic          push;
  logic [WIDTH_P-1:0] sel_gx;
  logic [WIDTH_P-1:0] sel_gy;

  // --------------------------------------------------------------------------
  // Grant selection. Offsets are scanned from far to near so the nearest
  // requester to rr_ptr is the last (winning) assignment.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    search_idx  = '0;
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_ch    = lock_ch_q;
    end else begin
      for (int i = CHANNELS_P - 1; i >= 0; i--) begin
        search_idx = {1'b0, rr_ptr_q} + (CW+1)'(i);
        if (search_idx >= NUM_CH) begin
          search_idx = search_idx - NUM_CH;
        end
        if (valid_i[search_idx[CW-1:0]]) begin
          grant_valid = 1'b1;
          grant_ch    = search_idx[CW-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Issue / return handshakes. A pop in the same cycle frees a slot, which is
  // the only route from mag_valid_i into mag_valid_o.
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_COUNT);
    head_ch    = tag_mem_q[rd_ptr_q];
    head_ready = 1'b0;
    sel_gx     = '0;
    sel_gy     = '0;
    for (int c = 0; c < CHANNELS_P; c++) begin
      if (head_ch == CW'(c)) begin
        head_ready = ready_i[c];
      end
      if (grant_ch == CW'(c)) begin
        sel_gx = gx_i[c*WIDTH_P +: WIDTH_P];
        sel_gy = gy_i[c*WIDTH_P +: WIDTH_P];
      end
    end
    ret_ready   = head_ready && !fifo_empty;
    pop         = mag_valid_i && ret_ready;
    issue_valid = grant_valid && (!fifo_full || pop);
    push        = issue_valid && mag_ready_i;
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced low while reset is held so that requests
  // present during reset are never forwarded.
  // --------------------------------------------------------------------------
  always_comb begin
    ready_o     = '0;
    valid_o     = '0;
    mag_valid_o = rstn_i && issue_valid;
    mag_gx_o    = (rstn_i && issue_valid) ? sel_gx : '0;
    mag_gy_o    = (rstn_i && issue_valid) ? sel_gy : '0;
    mag_ready_o = rstn_i && ret_ready;
    mag_o       = (rstn_i && !fifo_empty) ? mag_i : '0;
    for (int c = 0; c < CHANNELS_P; c++) begin
      ready_o[c] = rstn_i && push && (grant_ch == CW'(c));
      valid_o[c] = rstn_i && mag_valid_i && !fifo_empty && (head_ch == CW'(c));
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A stalled issue locks onto its channel so the payload
  // seen by the shared unit cannot change before it is accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (push) begin
      rr_ptr_d = (grant_ch == LAST_CH) ? '0 : grant_ch + CW'(1);
      lock_d   = 1'b0;
    end else if (issue_valid) begin
      lock_d    = 1'b1;
      lock_ch_d = grant_ch;
    end

    tag_mem_d = tag_mem_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_ch;
    end
    // Pointers wrap naturally because DEPTH_P is a power of two.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH_P; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < DEPTH_P; i++) begin
        tag_mem_q[i] <= tag_mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_magnitude_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_magnitude_arbiter
// Purpose  : Self-checking bench for magnitude_arbiter with a behavioural
//            shared unit (1-cycle latency, max + min/2 magnitude) and a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_magnitude_arbiter;

  localparam int C = 3;
  localparam int W = 8;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic [C-1:0]     valid_i;
  logic [C-1:0]     ready_o;
  logic [C*W-1:0]   gx_i;
  logic [C*W-1:0]   gy_i;
  logic             mag_valid_o;
  logic             mag_ready_i;
  logic [W-1:0]     mag_gx_o;
  logic [W-1:0]     mag_gy_o;
  logic             mag_valid_i;
  logic             mag_ready_o;
  logic [2*W-1:0]   mag_i;
  logic [C-1:0]     valid_o;
  logic [C-1:0]     ready_i;
  logic [2*W-1:0]   mag_o;

  magnitude_arbiter #(.WIDTH_P(W), .CHANNELS_P(C), .DEPTH_P(D)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .gx_i        (gx_i),
    .gy_i        (gy_i),
    .mag_valid_o (mag_valid_o),
    .mag_ready_i (mag_ready_i),
    .mag_gx_o    (mag_gx_o),
    .mag_gy_o    (mag_gy_o),
    .mag_valid_i (mag_valid_i),
    .mag_ready_o (mag_ready_o),
    .mag_i       (mag_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .mag_o       (mag_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner queue of in-flight results plus scheduler state.
  int m_rr      = 0;
  int m_lock    = 0;
  int m_lock_ch = 0;
  int m_tags[$];
  // Behavioural shared unit: results in issue order.
  logic [2*W-1:0] unit_q[$];
  bit             spurious = 1'b0;
  logic [2*W-1:0] spur_val = '0;
  // Expected handshakes for the current cycle.
  bit e_issue, e_pop, e_stall;
  int e_g;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(logic [C-1:0] v, int i);
    logic [C-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [2*W-1:0] unit_calc(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] mx, mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return (2*W)'(mx) + (2*W)'(mn >> 1);
  endfunction

  task automatic set_data(int gxb, int gyv);
    gx_i = '0;
    gy_i = '0;
    for (int c = 0; c < C; c++) begin
      gx_i = gx_i | ((C*W)'(gxb + c) << (c*W));
      gy_i = gy_i | ((C*W)'(gyv) << (c*W));
    end
  endtask

  // Drive the unit's result side, let logic settle, compare against model.
  task automatic settle();
    logic [C-1:0]   e_ready, e_vo;
    logic           e_mv, e_mro;
    logic [W-1:0]   e_gx, e_gy;
    logic [2*W-1:0] e_mo;
    bit             gex;
    int             g, h, cc;
    if (spurious) begin
      mag_valid_i = 1'b1;
      mag_i       = spur_val;
    end else if (unit_q.size() > 0) begin
      mag_valid_i = 1'b1;
      mag_i       = unit_q[0];
    end else begin
      mag_valid_i = 1'b0;
      mag_i       = '0;
    end
    #1;
    e_ready = '0; e_vo = '0; e_mv = 1'b0; e_mro = 1'b0;
    e_gx = '0; e_gy = '0; e_mo = '0;
    gex = 1'b0; g = 0; h = 0;
    e_issue = 1'b0; e_pop = 1'b0; e_stall = 1'b0; e_g = 0;
    if (rstn_i) begin
      if (m_lock != 0) begin
        gex = 1'b1;
        g   = m_lock_ch;
      end else begin
        for (int k = 0; k < C; k++) begin
          cc = (m_rr + k) % C;
          if (!gex && bit_of(valid_i, cc)) begin
            gex = 1'b1;
            g   = cc;
          end
        end
      end
      if (m_tags.size() > 0) begin
        h     = m_tags[0];
        e_mro = bit_of(ready_i, h);
        e_mo  = mag_i;
        e_vo  = C'(mag_valid_i) << h;
      end
      e_pop = mag_valid_i && e_mro;
      e_mv  = gex && ((m_tags.size() < D) || e_pop);
      if (e_mv) begin
        e_gx    = W'(gx_i >> (g*W));
        e_gy    = W'(gy_i >> (g*W));
        e_ready = C'(mag_ready_i) << g;
      end
      e_issue = e_mv && mag_ready_i;
      e_stall = e_mv && !mag_ready_i;
      e_g     = g;
    end
    check("ready_o",     64'(ready_o),     64'(e_ready));
    check("mag_valid_o", 64'(mag_valid_o), 64'(e_mv));
    check("mag_gx_o",    64'(mag_gx_o),    64'(e_gx));
    check("mag_gy_o",    64'(mag_gy_o),    64'(e_gy));
    check("mag_ready_o", 64'(mag_ready_o), 64'(e_mro));
    check("valid_o",     64'(valid_o),     64'(e_vo));
    check("mag_o",       64'(mag_o),       64'(e_mo));
  endtask

  // Commit the cycle's handshakes to the unit and the model at the edge.
  task automatic advance();
    logic         iss_dut, ret_dut;
    logic [W-1:0] gx, gy;
    iss_dut = mag_valid_o && mag_ready_i;
    ret_dut = mag_valid_i && mag_ready_o;
    gx      = mag_gx_o;
    gy      = mag_gy_o;
    @(posedge clk);
    if (!rstn_i) begin
      unit_q.delete();
      m_tags.delete();
      m_rr = 0; m_lock = 0; m_lock_ch = 0;
    end else begin
      if (ret_dut && !spurious && unit_q.size() > 0) void'(unit_q.pop_front());
      if (iss_dut) unit_q.push_back(unit_calc(gx, gy));
      if (e_pop) void'(m_tags.pop_front());
      if (e_issue) begin
        m_tags.push_back(e_g);
        m_rr   = (e_g + 1) % C;
        m_lock = 0;
      end else if (e_stall) begin
        m_lock    = 1;
        m_lock_ch = e_g;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    rstn_i      = 1'b0;
    valid_i     = '1;
    ready_i     = '0;
    mag_ready_i = 1'b1;
    mag_valid_i = 1'b0;
    mag_i       = '0;
    set_data(10, 4);

    // Reset: requests present but every output held low.
    settle();
    check("rst_mag_valid", 64'(mag_valid_o), 64'(0));
    check("rst_ready",     64'(ready_o),     64'(0));
    advance();
    idle(1);
    rstn_i  = 1'b1;
    ready_i = '1;

    // Round-robin rotation; results come back one cycle after issue.
    for (int k = 0; k < 7; k++) begin
      if (k == 6) valid_i = '0;
      settle();
      if (k < 6) begin
        check("rot_gx",    64'(mag_gx_o), 64'(10 + k % 3));
        check("rot_ready", 64'(ready_o),  64'(1 << (k % 3)));
      end
      if (k >= 1) begin
        check("rot_valid_o", 64'(valid_o), 64'(1 << ((k - 1) % 3)));
        check("rot_mag_o",   64'(mag_o),   64'(12 + (k - 1) % 3));
      end
      advance();
    end

    // Stall lock on channel 1; channel 0 arrives but must not preempt.
    set_data(20, 3);
    valid_i     = 3'b010;
    mag_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) valid_i = 3'b011;
      settle();
      check("stall_gx",    64'(mag_gx_o),    64'(21));
      check("stall_ready", 64'(ready_o),     64'(0));
      check("stall_valid", 64'(mag_valid_o), 64'(1));
      advance();
    end
    mag_ready_i = 1'b1;
    settle();
    check("stall_release", 64'(ready_o), 64'(3'b010));
    advance();
    valid_i = 3'b001;
    settle();
    check("after_stall_gx",    64'(mag_gx_o), 64'(20));
    check("after_stall_ready", 64'(ready_o),  64'(3'b001));
    advance();
    valid_i = '0;
    idle(3);

    // FIFO full: four issues (1,2,0,1) with results held.
    set_data(30, 0);
    valid_i = '1;
    ready_i = '0;
    idle(4);
    for (int s = 0; s < 2; s++) begin
      settle();
      check("full_no_issue", 64'(mag_valid_o), 64'(0));
      check("full_count",    64'(dut.count_q), 64'(4));
      advance();
    end
    ready_i = 3'b010;
    settle();
    check("full_pop_ready", 64'(mag_ready_o), 64'(1));
    check("full_pop_route", 64'(valid_o),     64'(3'b010));
    check("full_pop_mag",   64'(mag_o),       64'(31));
    check("full_issue",     64'(mag_valid_o), 64'(1));
    check("full_issue_gx",  64'(mag_gx_o),    64'(32));
    advance();
    check("full_count_kept", 64'(dut.count_q), 64'(4));
    valid_i = '0;
    ready_i = '1;
    idle(6);

    // Back-pressure routing: results owed to channel 2 then channel 0.
    set_data(40, 1);
    ready_i = '0;
    valid_i = 3'b100;
    idle(1);
    valid_i = 3'b001;
    idle(1);
    valid_i = '0;
    ready_i = 3'b011;
    for (int s = 0; s < 2; s++) begin
      settle();
      check("bp_mag_ready", 64'(mag_ready_o), 64'(0));
      check("bp_valid_o",   64'(valid_o),     64'(3'b100));
      advance();
    end
    ready_i = '1;
    settle();
    check("bp_release_valid", 64'(valid_o),     64'(3'b100));
    check("bp_release_ready", 64'(mag_ready_o), 64'(1));
    check("bp_release_mag",   64'(mag_o),       64'(42));
    advance();
    settle();
    check("bp_next_valid", 64'(valid_o), 64'(3'b001));
    check("bp_next_mag",   64'(mag_o),   64'(40));
    advance();
    idle(1);

    // Mid-operation reset with three tags in flight.
    set_data(50, 2);
    valid_i = '1;
    ready_i = '0;
    idle(3);
    valid_i = '0;
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_count",     64'(dut.count_q),  64'(0));
    check("arst_rr",        64'(dut.rr_ptr_q), 64'(0));
    check("arst_valid_o",   64'(valid_o),      64'(0));
    check("arst_mag_ready", 64'(mag_ready_o),  64'(0));
    settle();
    advance();
    rstn_i   = 1'b1;
    valid_i  = '1;
    ready_i  = '1;
    spurious = 1'b1;
    spur_val = 16'd99;
    settle();
    check("post_rst_no_route", 64'(valid_o),     64'(0));
    check("post_rst_no_ready", 64'(mag_ready_o), 64'(0));
    check("post_rst_mag_o",    64'(mag_o),       64'(0));
    check("post_rst_gx",       64'(mag_gx_o),    64'(50));
    check("post_rst_grant",    64'(ready_o),     64'(3'b001));
    advance();
    spurious = 1'b0;
    settle();
    check("post_rst_result_valid", 64'(valid_o), 64'(3'b001));
    check("post_rst_result_mag",   64'(mag_o),   64'(51));
    advance();
    valid_i = '0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/magnitude_arbiter.md
# magnitude_arbiter

Round-robin scheduler that shares one `magnitude` datapath among `CHANNELS_P` gradient streams, for example per-colour-channel Sobel pipelines. It sits between the per-channel gx/gy producers and a single magnitude unit. It issues one gradient pair per handshake to the shared unit and records the issuing channel in an in-order tag FIFO. It routes each returning magnitude back to the channel that issued it.

## Interface
Parameters:
- `WIDTH_P`, default 8: gradient width; magnitude width is 2*`WIDTH_P`.
- `CHANNELS_P`, default 3: number of requesting channels, 2..8.
- `DEPTH_P`, default 4: number of in-flight transactions held by the tag FIFO; power of two, at least 2.

Ports (`C` = `CHANNELS_P`, `W` = `WIDTH_P`):
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `valid_i` in C: per-channel request valid.
- `ready_o` out C: per-channel request ready.
- `gx_i` in C*W: channel c occupies bits [c*W +: W].
- `gy_i` in C*W: same packing as `gx_i`.
- `mag_valid_o` out 1: issue valid to the shared magnitude unit.
- `mag_ready_i` in 1: issue ready from the shared unit.
- `mag_gx_o` out W: gx of the granted channel.
- `mag_gy_o` out W: gy of the granted channel.
- `mag_valid_i` in 1: result valid from the shared unit.
- `mag_ready_o` out 1: result ready to the shared unit.
- `mag_i` in 2W: result magnitude.
- `valid_o` out C: per-channel result valid; one-hot or zero.
- `ready_i` in C: per-channel result ready.
- `mag_o` out 2W: result, broadcast to all channels; qualified by `valid_o`.

## Operation
- **State**
  - `rr_ptr`: ceil(log2 C) bits.
  - `lock`: 1 bit.
  - `lock_ch`: ceil(log2 C) bits.
  - Tag FIFO: `DEPTH_P` entries of ceil(log2 C) bits, with read and write pointers and an occupancy count of log2(DEPTH_P)+1 bits.
- **Grant selection**
  - When `lock`=0, the grant is the first channel c with `valid_i[c]`=1, searching c = `rr_ptr`, `rr_ptr`+1, …, wrapping modulo C.
  - When `lock`=1, the grant is `lock_ch`.
- **Issue**
  - `mag_valid_o` = (a grant exists) AND (FIFO not full OR a pop occurs this cycle).
  - `mag_gx_o`/`mag_gy_o` carry the granted channel's slice.
  - `ready_o[g]` = `mag_ready_i` AND `mag_valid_o`. All other `ready_o` bits are 0.
  - When `mag_valid_o` is 0, `mag_gx_o`/`mag_gy_o` are 0.
- **Issue handshake** (`mag_valid_o` AND `mag_ready_i`)
  - Push g into the tag FIFO.
  - `rr_ptr` <= (g+1) mod C.
  - `lock` <= 0.
- **Stall** (`mag_valid_o`=1, `mag_ready_i`=0)
  - `lock` <= 1 and `lock_ch` <= g.
  - This keeps the grant and payload stable until the handshake completes; a higher-priority arrival does not preempt it.
- **Return path** (tag FIFO head h)
  - `valid_o[h]` = `mag_valid_i` AND FIFO not empty. All other bits of `valid_o` are 0.
  - `mag_ready_o` = `ready_i[h]` AND FIFO not empty.
  - `mag_o` = `mag_i` when the FIFO is not empty, otherwise 0.
  - A return handshake (`mag_valid_i` AND `mag_ready_o`) pops the FIFO.
- **Result ordering:** the shared unit returns results in issue order, so the FIFO head always identifies the owner of `mag_i`.
- **FIFO boundary behaviour**
  - FIFO full with no pop that cycle: no issue.
  - FIFO full with a pop that cycle: issue allowed; push and pop occur together and occupancy is unchanged.
  - FIFO empty: `mag_ready_o`=0, so a spurious `mag_valid_i` is never accepted.
  - Read and write pointers wrap modulo `DEPTH_P`.
- **Reset** (asynchronous, while `rstn_i`=0)
  - `rr_ptr`=0, `lock`=0, `lock_ch`=0, FIFO pointers and count = 0.
  - All outputs 0: `ready_o`, `mag_valid_o`, `mag_gx_o`, `mag_gy_o`, `mag_ready_o`, `valid_o`, `mag_o`.
  - Reset asserted mid-transaction discards all in-flight tags. The shared unit must be reset by the same `rstn_i`.

## Timing
- Issue is zero-latency combinational: a request is forwarded in the same cycle it is granted.
- Return is zero-latency combinational: `mag_i` is routed to its channel in the same cycle it arrives.
- Arbiter state and FIFO state update on the rising edge.
- Arbitration latency is one cycle per grant, so a sustained single requester issues every cycle.
- With the 1-cycle shared magnitude unit, end-to-end latency from request to result is 1 cycle and full throughput is 1 transaction per cycle.
- Fairness: with all C channels requesting continuously and `mag_ready_i`=1, grants rotate 0,1,…,C-1,0,…. Worst-case wait is C-1 issue handshakes.
- No combinational path from `mag_valid_i` to `mag_valid_o` other than through the full-FIFO pop term.

## Test plan
- **Reset values:** hold `rstn_i`=0 with all `valid_i`=1 → every output is 0. Release reset → first grant goes to channel 0.
- **Round-robin rotation:** C=3, all channels request continuously, `mag_ready_i`=1, unit latency 1. Channel c drives gx=10+c, gy=4 → issue order 0,1,2,0,1,2. Channel 0 receives `mag_o`=12, channel 1 receives 13, channel 2 receives 14, each on the matching `valid_o` bit.
- **Stall lock:** channel 1 is granted and `mag_ready_i`=0 for 3 cycles. Channel 0 raises `valid_i` during the stall → `mag_gx_o`/`mag_gy_o` stay on channel 1's data and `ready_o` stays 0. On release, channel 1 handshakes, then channel 2 is granted if requesting, otherwise channel 0.
- **FIFO full:** `DEPTH_P`=4, all `ready_i`=0 (results held), 4 issues → `mag_valid_o` drops to 0. Assert `ready_i` on the head channel → pop and issue occur in the same cycle; occupancy stays 4.
- **Back-pressure routing:** results pending for channels 2 and 0, `ready_i[2]`=0 for 2 cycles → `mag_ready_o`=0 and `valid_o`=3'b100. After `ready_i[2]`=1 → the next result is routed to channel 0 (`valid_o`=3'b001).
- **Mid-operation reset:** assert `rstn_i` low with 3 tags in flight → FIFO count = 0 and `rr_ptr` = 0 immediately (asynchronously). After release, no stale result is routed, and the first new request is from channel 0.
